// File: rtl/riscv_mdu_pkg.sv
// riscv_mdu_pkg: shared types and constants for the RV32M multiply/divide unit.
//   mdu_op_e    - funct3 encodings of the eight M-extension operations
//   mdu_state_e - controller states of the iterative unit
//   M_FUNCT7    - funct7 value that routes an OP instruction to this unit
//   helpers     - operand signedness / op-class decode on funct3
package riscv_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  localparam logic [6:0] M_OPCODE = 7'b0110011;
  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  function automatic logic op_is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input mdu_op_e op);
    return op[2] & op[1];
  endfunction

  // rs1 is unsigned only for MULHU/DIVU/REMU
  function automatic logic op_a_signed(input mdu_op_e op);
    return !(op == OP_MULHU || op == OP_DIVU || op == OP_REMU);
  endfunction

  // rs2 is signed only for MUL/MULH/DIV/REM
  function automatic logic op_b_signed(input mdu_op_e op);
    return (op == OP_MUL || op == OP_MULH || op == OP_DIV || op == OP_REM);
  endfunction

endpackage

// File: rtl/riscv_mdu_if.sv
// riscv_mdu_if: request/response bundle between the core datapath and the MDU.
//   start, kill, funct3, op_a, op_b : core -> MDU
//   busy, done, result              : MDU -> core
// master = core side, slave = MDU side.
interface riscv_mdu_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              kill;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  modport master (
    output start, kill, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/riscv_mdu_step.sv
// mdu_step: one combinational radix-2 step of the iterative MDU.
//   is_div : 0 = shift-add multiply step, 1 = restoring shift-subtract step
//   hi_i/lo_i : working pair (multiply: partial product / multiplier;
//               divide: partial remainder / dividend shifting into quotient)
//   b_i    : multiplicand or divisor magnitude
//   hi_o/lo_o : working pair after the step
module mdu_step #(
  parameter int DATA_W = 32
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  always_comb begin
    sum     = {1'b0, hi_i} + {1'b0, (lo_i[0] ? b_i : {DATA_W{1'b0}})};
    shifted = {hi_i, lo_i[DATA_W-1]};
    diff    = shifted - {1'b0, b_i};
    hi_o    = sum[DATA_W:1];
    lo_o    = {sum[0], lo_i[DATA_W-1:1]};
    if (is_div) begin
      // partial remainder stays below the divisor, so a borrow shows in the top bit
      if (!diff[DATA_W]) begin
        hi_o = diff[DATA_W-1:0];
        lo_o = {lo_i[DATA_W-2:0], 1'b1};
      end else begin
        hi_o = shifted[DATA_W-1:0];
        lo_o = {lo_i[DATA_W-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/riscv_mdu.sv
// riscv_mdu: iterative RV32M multiply/divide unit, UNROLL bits per CALC cycle.
//   clk, reset : clock (rising edge) and asynchronous active-high reset
//   bus        : slave side of riscv_mdu_if (start/kill/funct3/op_a/op_b in,
//                busy/done/result out)
// Flow: IDLE/DONE --accept--> CALC (N cycles) --> FIX --> DONE (1 cycle).
// Divide-by-zero and signed overflow skip CALC and go straight to FIX.
// DATA_W must be even and >= 8; UNROLL must divide DATA_W.
module riscv_mdu
  import riscv_mdu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int UNROLL = 1
) (
  input logic         clk,
  input logic         reset,
  riscv_mdu_if.slave  bus
);
  localparam int N     = DATA_W / UNROLL;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [DATA_W-1:0] MIN_INT = {1'b1, {(DATA_W-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_in;
  logic [DATA_W-1:0] hi_q, lo_q, b_q, fast_val_q, result_q;
  logic              neg_q, neg_rem_q, fast_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              idle_or_done, accept;
  logic              sign_a, sign_b, div_zero, div_ovf, fast_in;
  logic [DATA_W-1:0] a_mag, b_mag, fast_val_in, fix_val;

  logic [UNROLL:0][DATA_W-1:0] hi_c, lo_c;

  assign op_in        = mdu_op_e'(bus.funct3);
  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  // kill drops a same-edge request
  assign accept       = idle_or_done && bus.start && !bus.kill;

  // Accept-time decode: magnitudes, result signs and fast-path detection
  always_comb begin
    sign_a   = op_a_signed(op_in) & bus.op_a[DATA_W-1];
    sign_b   = op_b_signed(op_in) & bus.op_b[DATA_W-1];
    a_mag    = sign_a ? -bus.op_a : bus.op_a;
    b_mag    = sign_b ? -bus.op_b : bus.op_b;
    div_zero = op_is_div(op_in) && (bus.op_b == '0);
    div_ovf  = op_is_div(op_in) && op_a_signed(op_in) &&
               (bus.op_a == MIN_INT) && (bus.op_b == '1);
    fast_in  = div_zero || div_ovf;
    if (div_zero) begin
      fast_val_in = op_is_rem(op_in) ? bus.op_a : '1;
    end else begin
      fast_val_in = op_is_rem(op_in) ? '0 : MIN_INT;
    end
  end

  // Unrolled step chain
  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    mdu_step #(.DATA_W(DATA_W)) u_step (
      .is_div (op_q[2]),
      .hi_i   (hi_c[g]),
      .lo_i   (lo_c[g]),
      .b_i    (b_q),
      .hi_o   (hi_c[g+1]),
      .lo_o   (lo_c[g+1])
    );
  end

  // FIX-stage sign correction and result selection
  always_comb begin
    logic [2*DATA_W-1:0] prod, prod_n;
    logic [DATA_W-1:0]   quot, rem;
    prod   = {hi_q, lo_q};
    prod_n = neg_q ? -prod : prod;
    quot   = neg_q ? -lo_q : lo_q;
    rem    = neg_rem_q ? -hi_q : hi_q;
    if (fast_q) begin
      fix_val = fast_val_q;
    end else if (op_is_div(op_q)) begin
      fix_val = op_is_rem(op_q) ? rem : quot;
    end else if (op_q == OP_MUL) begin
      fix_val = prod_n[DATA_W-1:0];
    end else begin
      fix_val = prod_n[2*DATA_W-1:DATA_W];
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) state_d = fast_in ? ST_FIX : ST_CALC;
        ST_CALC: if (cnt_q == CNT_W'(N - 1)) state_d = ST_FIX;
        ST_FIX:  state_d = ST_DONE;
        ST_DONE: begin
          if (bus.start) state_d = fast_in ? ST_FIX : ST_CALC;
          else           state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath registers: load at accept, iterate in CALC, publish in FIX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= OP_MUL;
      hi_q       <= '0;
      lo_q       <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      fast_q     <= 1'b0;
      fast_val_q <= '0;
      result_q   <= '0;
    end else if (accept) begin
      op_q       <= op_in;
      hi_q       <= '0;
      lo_q       <= a_mag;
      b_q        <= b_mag;
      cnt_q      <= '0;
      neg_q      <= sign_a ^ sign_b;
      neg_rem_q  <= sign_a;
      fast_q     <= fast_in;
      fast_val_q <= fast_val_in;
    end else if (!bus.kill) begin
      if (state_q == ST_CALC) begin
        hi_q  <= hi_c[UNROLL];
        lo_q  <= lo_c[UNROLL];
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == ST_FIX) result_q <= fix_val;
    end
  end

  assign bus.busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_riscv_mdu.sv
// tb_riscv_mdu: randomized and directed bench for riscv_mdu with two instances,
// UNROLL=1 (m1/dut1) and UNROLL=4 (m4/dut4), checked against a plain-arithmetic
// reference of the RV32M rules.
module tb_riscv_mdu;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  riscv_mdu_if #(.DATA_W(32)) m1();
  riscv_mdu_if #(.DATA_W(32)) m4();

  riscv_mdu #(.DATA_W(32), .UNROLL(1)) dut1 (.clk(clk), .reset(reset), .bus(m1.slave));
  riscv_mdu #(.DATA_W(32), .UNROLL(4)) dut4 (.clk(clk), .reset(reset), .bus(m4.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic kl, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel == 0) begin
      m1.start = st; m1.kill = kl; m1.funct3 = f; m1.op_a = a; m1.op_b = b;
    end else begin
      m4.start = st; m4.kill = kl; m4.funct3 = f; m4.op_a = a; m4.op_b = b;
    end
  endtask

  function automatic logic s_done(input int sel);
    return (sel == 0) ? m1.done : m4.done;
  endfunction

  function automatic logic s_busy(input int sel);
    return (sel == 0) ? m1.busy : m4.busy;
  endfunction

  function automatic logic [31:0] s_result(input int sel);
    return (sel == 0) ? m1.result : m4.result;
  endfunction

  // Reference: RV32M semantics via 64-bit arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    logic [31:0]        r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (f)
      3'd0: begin sp = sa * sb; r = sp[31:0]; end
      3'd1: begin sp = sa * sb; r = sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); r = sp[63:32]; end
      3'd3: begin up = ua * ub; r = up[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin sp = sa / sb; r = sp[31:0]; end
      end
      3'd5: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin up = ua / ub; r = up[31:0]; end
      end
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin sp = sa % sb; r = sp[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin up = ua % ub; r = up[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  // Called #1 after the accept edge. Junk requests are thrown at the unit while
  // it is busy; they must not disturb the op in flight.
  task automatic wait_done(input int sel, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input string tag);
    int k, busy_n, nn, exp_k;
    bit got;
    nn     = (sel == 0) ? 32 : 8;
    exp_k  = is_fast(f, a, b) ? 1 : nn + 1;
    k      = 0;
    busy_n = 0;
    got    = 0;
    while (!got && k < 100) begin
      if (k > 0 && s_done(sel)) begin
        got = 1;
      end else begin
        if (s_busy(sel)) busy_n++;
        drive(sel, 1'($urandom_range(1)), 1'b0, 3'($urandom_range(7)), $urandom, $urandom);
        @(posedge clk); #1;
        k++;
      end
    end
    drive(sel, 1'b0, 1'b0, f, a, b);
    check({tag, "/done_seen"}, 32'(got), 32'd1);
    check({tag, "/done_edge"}, 32'(k + 1), 32'(exp_k + 1));
    check({tag, "/busy_cycles"}, 32'(busy_n), 32'(exp_k));
    check({tag, "/result"}, s_result(sel), exp);
    check({tag, "/busy_in_done"}, 32'(s_busy(sel)), 32'd0);
  endtask

  task automatic issue(input int sel, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input string tag);
    @(negedge clk);
    drive(sel, 1'b1, 1'b0, f, a, b);
    @(posedge clk); #1;
    wait_done(sel, f, a, b, exp, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    logic [2:0]  f;
    logic [31:0] a, b;

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst/result1", m1.result, 32'd0);
    check("rst/busy1", 32'(m1.busy), 32'd0);
    check("rst/done1", 32'(m1.done), 32'd0);
    check("rst/result4", m4.result, 32'd0);
    check("rst/busy4", 32'(m4.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors, UNROLL=1
    issue(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
    issue(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
    issue(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    issue(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    issue(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div");
    issue(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem");
    issue(0, 3'd5, 32'd100, 32'd7, 32'd14, "divu");
    issue(0, 3'd7, 32'd100, 32'd7, 32'd2, "remu");
    issue(0, 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, "divu0");
    issue(0, 3'd7, 32'd100, 32'd0, 32'd100, "remu0");
    issue(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    issue(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");
    issue(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_again");

    // kill in CALC cycle 10: back to IDLE, no done, result held
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b1, 3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    check("kill/busy", 32'(m1.busy), 32'd0);
    dn = 0;
    repeat (40) begin @(posedge clk); #1; if (m1.done) dn++; end
    check("kill/no_done", 32'(dn), 32'd0);
    check("kill/result_held", m1.result, 32'hFFFF_FFEB);

    // kill and start at the same edge: request dropped
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 3'd0, 32'd3, 32'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'd0, 32'd3, 32'd3);
    check("killstart/busy", 32'(m1.busy), 32'd0);
    @(posedge clk); #1;
    check("killstart/done", 32'(m1.done), 32'd0);

    // async reset mid-CALC
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 3'd5, 32'd1000, 32'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'd5, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst/busy", 32'(m1.busy), 32'd0);
    check("arst/done", 32'(m1.done), 32'd0);
    check("arst/result", m1.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (40) begin @(posedge clk); #1; if (m1.done) dn++; end
    check("arst/no_done", 32'(dn), 32'd0);

    // UNROLL=4 back-to-back with start held in the DONE cycle
    issue(1, 3'd0, 32'd3, 32'd5, 32'd15, "b2b_mul");
    drive(1, 1'b1, 1'b0, 3'd4, 32'd15, 32'd4);
    @(posedge clk); #1;
    wait_done(1, 3'd4, 32'd15, 32'd4, 32'd3, "b2b_div");

    // Randomized against the reference on both instances
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(7)); a = pick(); b = pick();
      issue(0, f, a, b, ref_mdu(f, a, b), "rnd_u1");
    end
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(7)); a = pick(); b = pick();
      issue(1, f, a, b, ref_mdu(f, a, b), "rnd_u4");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/riscv_mdu.md
Name: riscv_mdu

Overview:
Parametrised iterative RV32M multiply/divide unit for the next-generation core. It is driven by the Datapath when opcode=0110011 and funct7=0000001, and executes all eight M-extension ops selected by Funct3. It is a multi-cycle unit with a start/busy/done handshake and a kill input so the core can stall or flush around it. Throughput and area trade off through UNROLL, the number of bits retired per cycle.

Parameters:
DATA_W, 32, operand/result width; must be even and >= 8
UNROLL, 1, radix bits processed per CALC cycle; must divide DATA_W
N (localparam), DATA_W/UNROLL, number of CALC cycles

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled at a rising edge when FSM is IDLE or DONE
kill  input  1  synchronous abort (pipeline flush); returns to IDLE, no done
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  DATA_W  rs1 value
op_b  input  DATA_W  rs2 value
busy  output  1  high in CALC and FIX; core stalls on busy
done  output  1  single-cycle pulse, high in DONE state
result  output  DATA_W  registered result; valid when done, held until next accept

Behaviour:
- Reset (async, any state): FSM=IDLE, busy=0, done=0, result=0, all internal accumulators and counter=0.
- States: IDLE, CALC, FIX, DONE.
- Accept: start=1 at edge E0 while IDLE or DONE latches funct3, |op_a|/|op_b| per signedness, result sign flags, counter=0.
  - Normal ops go to CALC.
  - Fast-path ops go directly to FIX.
- Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats op_a signed, op_b unsigned; MULHU/DIVU/REMU treat both as unsigned.
- CALC: each cycle performs UNROLL shift-add (multiply) or restoring shift-subtract (divide) steps; counter increments; after N cycles go to FIX.
- Multiply: 2*DATA_W-bit product of magnitudes. MUL returns the low half; MULH/MULHSU/MULHU return the high half, after two's-complement negation of the full 2*DATA_W product when the result sign is negative.
- Divide: quotient and remainder of magnitudes. Quotient is negated if the operand signs differ (signed ops). Remainder takes the dividend's sign. Truncation is toward zero.
- Fast path, decided at accept:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give op_a unchanged.
  - Signed overflow, DIV with op_a=MIN_INT and op_b=-1: gives MIN_INT; REM gives 0.
- FIX: apply sign correction, register result, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. If start=1 at that edge, accept instead (back-to-back, no bubble).
- Latency:
  - Normal: done high in the cycle after edge E0+N+1 (sampled high at E0+N+2).
  - Fast path: sampled high at E0+2.
- start while busy=1: ignored, no effect on in-flight op.
- kill: has priority over start and state progression; takes effect at the next edge from any state. FSM goes to IDLE, done stays 0, result holds its previous value. kill and start at the same edge: kill wins, request dropped.
- busy is 0 in IDLE and DONE, so the core may issue in the DONE cycle.
- Mid-operation reset: immediate IDLE and zeroed outputs; no done ever generated for the aborted op.

Decomposition:
- Shared package riscv_mdu_pkg:
  - funct3 enum mdu_op_e with the eight encodings above.
  - FSM enum mdu_state_e.
  - Constant M_FUNCT7=7'b0000001, used by Controller/ALUController to route to this unit.
- Sub-module mdu_step: one combinational radix-2 step, add-or-pass for multiply and trial-subtract for divide. It is instantiated UNROLL times in a generate chain inside riscv_mdu.

Test Plan:
- DATA_W=32, UNROLL=1: MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; done sampled high exactly 34 edges after the accept edge; busy high for 33 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- Fast path:
  - DIVU 100 / 0 -> 0xFFFFFFFF and REMU 100 / 0 -> 100, each done at accept+2.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, also at accept+2.
- kill asserted at CALC cycle 10 -> IDLE next edge, done never pulses, result unchanged. Async reset pulse mid-CALC -> result=0, busy=0 immediately.
- UNROLL=4 (N=8): back-to-back MUL 3x5 then DIV 15/4 with start held in the DONE cycle -> results 15 then 3. Second done at first done + 10 edges; start during busy ignored.
